// File: rtl/bp_fe_lce_cmd_rx.sv
// Front-end I-cache LCE command receiver.
// Clears every tag set after reset and then applies CCE->LCE commands to the
// icache tag/data arrays. It raises one-cycle event pulses for the FE LCE
// request FSM and returns sync/invalidate acks on the LCE response channel.
// Optional macro BP_FE_LCE_CMD_PROTOCOL_CHECK_EN enables the sticky error_o
// flag. The flag is set by an unknown msg_type, or by a set_tag/data command
// whose way_id is out of range.
module bp_fe_lce_cmd_rx #(
  parameter int unsigned cce_id_width_p = 3,
  parameter int unsigned lce_id_width_p = 4,
  parameter int unsigned paddr_width_p  = 40,
  parameter int unsigned sets_p         = 64,
  parameter int unsigned assoc_p        = 8,
  parameter int unsigned block_width_p  = 512,
  parameter int unsigned dword_width_p  = 64,
  parameter int unsigned ptag_width_p   = 28,
  localparam int unsigned index_w = $clog2(sets_p),
  localparam int unsigned way_w   = $clog2(assoc_p),
  localparam int unsigned cmd_w   = block_width_p + way_w + paddr_width_p + cce_id_width_p + 4,
  localparam int unsigned resp_w  = 2 + paddr_width_p + lce_id_width_p + cce_id_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [lce_id_width_p-1:0]   lce_id_i,
  input  logic [cmd_w-1:0]            lce_cmd_i,
  input  logic                        lce_cmd_v_i,
  output logic                        lce_cmd_yumi_o,
  output logic                        tag_mem_v_o,
  output logic [1:0]                  tag_mem_op_o,
  output logic [index_w-1:0]          tag_mem_index_o,
  output logic [way_w-1:0]            tag_mem_way_o,
  output logic [ptag_width_p-1:0]     tag_mem_tag_o,
  input  logic                        tag_mem_ready_i,
  output logic                        data_mem_v_o,
  output logic [index_w-1:0]          data_mem_index_o,
  output logic [way_w-1:0]            data_mem_way_o,
  output logic [block_width_p-1:0]    data_mem_data_o,
  input  logic                        data_mem_ready_i,
  output logic                        uc_data_v_o,
  output logic [dword_width_p-1:0]    uc_data_o,
  output logic                        cce_data_received_o,
  output logic                        uncached_data_received_o,
  output logic                        set_tag_received_o,
  output logic                        set_tag_wakeup_received_o,
  output logic                        coherence_blocked_o,
  output logic                        init_done_o,
  output logic [resp_w-1:0]           lce_resp_o,
  output logic                        lce_resp_v_o,
  input  logic                        lce_resp_yumi_i,
  output logic                        error_o
);

  localparam int unsigned addr_lsb = 4 + cce_id_width_p;
  localparam int unsigned way_lsb  = addr_lsb + paddr_width_p;
  localparam int unsigned data_lsb = way_lsb + way_w;

  typedef enum logic [1:0] {e_clear, e_ready, e_send_resp} state_e;

  state_e                      state_r, state_n;
  logic [index_w-1:0]          cnt_r, cnt_n;
  logic                        init_done_r, init_done_n;
  logic [1:0]                  resp_type_r, resp_type_n;
  logic [paddr_width_p-1:0]    resp_addr_r;
  logic [cce_id_width_p-1:0]   resp_dst_r;
  logic                        resp_load;
  logic                        tag_v;

  logic [3:0]                  cmd_type;
  logic [cce_id_width_p-1:0]   cmd_src;
  logic [paddr_width_p-1:0]    cmd_addr;
  logic [way_w-1:0]            cmd_way;
  logic [block_width_p-1:0]    cmd_data;
  logic [index_w-1:0]          cmd_index;
  logic [ptag_width_p-1:0]     cmd_tag;
  logic                        way_bad;

  assign cmd_type  = lce_cmd_i[3:0];
  assign cmd_src   = lce_cmd_i[4 +: cce_id_width_p];
  assign cmd_addr  = lce_cmd_i[addr_lsb +: paddr_width_p];
  assign cmd_way   = lce_cmd_i[way_lsb +: way_w];
  assign cmd_data  = lce_cmd_i[data_lsb +: block_width_p];
  assign cmd_index = cmd_addr[6 +: index_w];
  assign cmd_tag   = cmd_addr[paddr_width_p-1 -: ptag_width_p];

`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
  logic bad_cmd;
  assign way_bad = ({1'b0, cmd_way} >= (way_w + 1)'(assoc_p));
`else
  assign way_bad = 1'b0;
`endif

  // State, clear counter, init flag and latched response fields
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_clear;
      cnt_r       <= '0;
      init_done_r <= 1'b0;
      resp_type_r <= '0;
      resp_addr_r <= '0;
      resp_dst_r  <= '0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      init_done_r <= init_done_n;
      if (resp_load) begin
        resp_type_r <= resp_type_n;
        resp_addr_r <= cmd_addr;
        resp_dst_r  <= cmd_src;
      end
    end
  end

  // Next-state decode, array writes, handshakes and event pulses
  always_comb begin
    state_n                   = state_r;
    cnt_n                     = cnt_r;
    init_done_n               = init_done_r;
    resp_load                 = 1'b0;
    resp_type_n               = 2'd0;
    tag_v                     = 1'b0;
    tag_mem_op_o              = 2'd0;
    tag_mem_index_o           = '0;
    tag_mem_way_o             = '0;
    tag_mem_tag_o             = '0;
    data_mem_v_o              = 1'b0;
    data_mem_index_o          = '0;
    data_mem_way_o            = '0;
    data_mem_data_o           = '0;
    uc_data_v_o               = 1'b0;
    uc_data_o                 = '0;
    lce_cmd_yumi_o            = 1'b0;
    cce_data_received_o       = 1'b0;
    uncached_data_received_o  = 1'b0;
    set_tag_received_o        = 1'b0;
    set_tag_wakeup_received_o = 1'b0;
    coherence_blocked_o       = 1'b0;
    lce_resp_v_o              = 1'b0;
`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
    bad_cmd                   = 1'b0;
`endif
    case (state_r)
      e_clear: begin
        tag_v           = 1'b1;
        tag_mem_index_o = cnt_r;
        if (tag_mem_ready_i) begin
          if (cnt_r == index_w'(sets_p - 1)) begin
            state_n     = e_ready;
            init_done_n = 1'b1;
          end else begin
            cnt_n = cnt_r + index_w'(1);
          end
        end
      end
      e_ready: begin
        if (lce_cmd_v_i) begin
          if ((cmd_type == 4'd1 || cmd_type == 4'd2 || cmd_type == 4'd3) && way_bad) begin
            lce_cmd_yumi_o = 1'b1;
`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
            bad_cmd        = 1'b1;
`endif
          end else begin
            case (cmd_type)
              4'd0: begin
                lce_cmd_yumi_o = 1'b1;
                resp_load      = 1'b1;
                resp_type_n    = 2'd0;
                state_n        = e_send_resp;
              end
              4'd1, 4'd2, 4'd5: begin
                tag_v           = 1'b1;
                tag_mem_op_o    = (cmd_type == 4'd5) ? 2'd2 : 2'd1;
                tag_mem_index_o = cmd_index;
                tag_mem_way_o   = cmd_way;
                tag_mem_tag_o   = cmd_tag;
                if (tag_mem_ready_i) begin
                  lce_cmd_yumi_o            = 1'b1;
                  set_tag_received_o        = (cmd_type == 4'd1);
                  set_tag_wakeup_received_o = (cmd_type == 4'd2);
                  if (cmd_type == 4'd5) begin
                    resp_load   = 1'b1;
                    resp_type_n = 2'd1;
                    state_n     = e_send_resp;
                  end
                end else begin
                  coherence_blocked_o = 1'b1;
                end
              end
              4'd3: begin
                data_mem_v_o     = 1'b1;
                data_mem_index_o = cmd_index;
                data_mem_way_o   = cmd_way;
                data_mem_data_o  = cmd_data;
                if (data_mem_ready_i) begin
                  lce_cmd_yumi_o      = 1'b1;
                  cce_data_received_o = 1'b1;
                end else begin
                  coherence_blocked_o = 1'b1;
                end
              end
              4'd4: begin
                lce_cmd_yumi_o           = 1'b1;
                uc_data_v_o              = 1'b1;
                uc_data_o                = cmd_data[dword_width_p-1:0];
                uncached_data_received_o = 1'b1;
              end
              default: begin
                lce_cmd_yumi_o = 1'b1;
`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
                bad_cmd        = 1'b1;
`endif
              end
            endcase
          end
        end
      end
      e_send_resp: begin
        lce_resp_v_o = 1'b1;
        if (lce_resp_yumi_i) state_n = e_ready;
      end
      default: state_n = e_clear;
    endcase
  end

  // Keep the clear write off the array while reset is held
  assign tag_mem_v_o = tag_v & ~reset_i;
  assign init_done_o = init_done_r;
  assign lce_resp_o  = lce_resp_v_o ? {resp_type_r, resp_addr_r, lce_id_i, resp_dst_r} : '0;

`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
  logic error_r;

  // Sticky illegal-command flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (bad_cmd) begin
      error_r <= 1'b1;
      $error("bp_fe_lce_cmd_rx: illegal command type %0d way %0d", cmd_type, cmd_way);
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fe_lce_cmd_rx.sv
// Scoreboard bench for bp_fe_lce_cmd_rx: directed cases plus randomized commands
// checked against a behavioural command model.
module tb_bp_fe_lce_cmd_rx;
  localparam int CCE_W = 3, LCE_W = 4, PA_W = 40, SETS = 64, ASSOC = 8;
  localparam int BLK = 512, DW = 64, PT = 28, IDX_W = 6, WAY_W = 3;
  localparam int CMD_W  = BLK + WAY_W + PA_W + CCE_W + 4;
  localparam int RESP_W = 2 + PA_W + LCE_W + CCE_W;
  localparam logic [LCE_W-1:0] MY_ID = 4'hA;
`ifdef BP_FE_LCE_CMD_PROTOCOL_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0, reset_i;
  logic [LCE_W-1:0] lce_id_i;
  logic [CMD_W-1:0] lce_cmd_i;
  logic lce_cmd_v_i, lce_cmd_yumi_o;
  logic tag_mem_v_o; logic [1:0] tag_mem_op_o; logic [IDX_W-1:0] tag_mem_index_o;
  logic [WAY_W-1:0] tag_mem_way_o; logic [PT-1:0] tag_mem_tag_o; logic tag_mem_ready_i;
  logic data_mem_v_o; logic [IDX_W-1:0] data_mem_index_o; logic [WAY_W-1:0] data_mem_way_o;
  logic [BLK-1:0] data_mem_data_o; logic data_mem_ready_i;
  logic uc_data_v_o; logic [DW-1:0] uc_data_o;
  logic cce_data_received_o, uncached_data_received_o, set_tag_received_o, set_tag_wakeup_received_o;
  logic coherence_blocked_o, init_done_o, lce_resp_v_o, lce_resp_yumi_i, error_o;
  logic [RESP_W-1:0] lce_resp_o;

  bp_fe_lce_cmd_rx dut (
    .clk_i(clk), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .lce_cmd_i(lce_cmd_i), .lce_cmd_v_i(lce_cmd_v_i), .lce_cmd_yumi_o(lce_cmd_yumi_o),
    .tag_mem_v_o(tag_mem_v_o), .tag_mem_op_o(tag_mem_op_o), .tag_mem_index_o(tag_mem_index_o),
    .tag_mem_way_o(tag_mem_way_o), .tag_mem_tag_o(tag_mem_tag_o), .tag_mem_ready_i(tag_mem_ready_i),
    .data_mem_v_o(data_mem_v_o), .data_mem_index_o(data_mem_index_o), .data_mem_way_o(data_mem_way_o),
    .data_mem_data_o(data_mem_data_o), .data_mem_ready_i(data_mem_ready_i),
    .uc_data_v_o(uc_data_v_o), .uc_data_o(uc_data_o),
    .cce_data_received_o(cce_data_received_o), .uncached_data_received_o(uncached_data_received_o),
    .set_tag_received_o(set_tag_received_o), .set_tag_wakeup_received_o(set_tag_wakeup_received_o),
    .coherence_blocked_o(coherence_blocked_o), .init_done_o(init_done_o),
    .lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o), .lce_resp_yumi_i(lce_resp_yumi_i),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  // One consumed command as seen at the array / event interface
  typedef struct packed {
    logic tag_v; logic [1:0] op; logic [IDX_W-1:0] tidx; logic [WAY_W-1:0] tway; logic [PT-1:0] tag;
    logic data_v; logic [IDX_W-1:0] didx; logic [WAY_W-1:0] dway; logic [BLK-1:0] data;
    logic uc_v; logic [DW-1:0] uc; logic [3:0] pulses;  // {cce_data, uncached, set_tag, wakeup}
  } ev_t;

  ev_t exp_q[$];
  logic [RESP_W-1:0] resp_q[$];
  int total = 0, bad = 0;
  bit resp_auto = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [3:0] mt, input logic [2:0] src,
                                          input logic [PA_W-1:0] a, input logic [WAY_W-1:0] w,
                                          input logic [BLK-1:0] d);
    return {d, w, a, src, mt};
  endfunction

  // Reference model: what one command must do once it is consumed
  task automatic predict(input logic [CMD_W-1:0] c);
    ev_t e;
    logic [3:0] mt; logic [2:0] src; logic [PA_W-1:0] a; logic [WAY_W-1:0] w; logic [BLK-1:0] d;
    {d, w, a, src, mt} = c;
    e = '0;
    case (mt)
      4'd0: resp_q.push_back({2'd0, a, MY_ID, src});
      4'd1, 4'd2, 4'd5: begin
        e.tag_v = 1'b1; e.op = (mt == 4'd5) ? 2'd2 : 2'd1;
        e.tidx = IDX_W'((a / 64) % SETS); e.tway = w; e.tag = PT'(a >> (PA_W - PT));
        if (mt == 4'd1) e.pulses = 4'b0010;
        if (mt == 4'd2) e.pulses = 4'b0001;
        if (mt == 4'd5) resp_q.push_back({2'd1, a, MY_ID, src});
      end
      4'd3: begin
        e.data_v = 1'b1; e.didx = IDX_W'((a / 64) % SETS); e.dway = w; e.data = d; e.pulses = 4'b1000;
      end
      4'd4: begin e.uc_v = 1'b1; e.uc = d[DW-1:0]; e.pulses = 4'b0100; end
      default: ;
    endcase
    exp_q.push_back(e);
  endtask

  // Hold a command valid until it is consumed; optionally jitter the array readies
  task automatic drive_cmd(input logic [CMD_W-1:0] c, input bit rnd);
    bit got = 1'b0;
    lce_cmd_i = c; lce_cmd_v_i = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      if (rnd) begin
        tag_mem_ready_i = 1'($urandom % 2);
        data_mem_ready_i = 1'($urandom % 2);
      end
      @(negedge clk);
      got = lce_cmd_yumi_o;
      @(posedge clk); #1;
    end
    if (!got) chk(1'b0, "cmd_timeout", 640'(c[3:0]), 640'd1);
    lce_cmd_v_i = 1'b0;
  endtask

  // Response acceptor, random when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_auto) lce_resp_yumi_i = 1'($urandom % 2);
    end
  end

  // Monitor: compares every consumed command and every presented response
  always @(negedge clk) begin : mon
    ev_t o, e;
    if (!reset_i) begin
      if (lce_cmd_yumi_o) begin
        o = '0;
        if (tag_mem_v_o && tag_mem_ready_i) begin
          o.tag_v = 1'b1; o.op = tag_mem_op_o; o.tidx = tag_mem_index_o; o.tway = tag_mem_way_o; o.tag = tag_mem_tag_o;
        end
        if (data_mem_v_o && data_mem_ready_i) begin
          o.data_v = 1'b1; o.didx = data_mem_index_o; o.dway = data_mem_way_o; o.data = data_mem_data_o;
        end
        if (uc_data_v_o) begin o.uc_v = 1'b1; o.uc = uc_data_o; end
        o.pulses = {cce_data_received_o, uncached_data_received_o, set_tag_received_o, set_tag_wakeup_received_o};
        if (exp_q.size() == 0) chk(1'b0, "cmd_unexpected", 640'(o), 640'd0);
        else begin
          e = exp_q.pop_front();
          chk(o == e, "cmd_event", 640'(o), 640'(e));
        end
      end else if (init_done_o) begin
        chk({cce_data_received_o, uncached_data_received_o, set_tag_received_o,
             set_tag_wakeup_received_o, uc_data_v_o} == 5'd0, "stray_pulse",
            640'({cce_data_received_o, uncached_data_received_o, set_tag_received_o,
                  set_tag_wakeup_received_o, uc_data_v_o}), 640'd0);
      end
      if (lce_resp_v_o) begin
        chk(!lce_cmd_yumi_o, "cmd_during_resp", 640'(lce_cmd_yumi_o), 640'd0);
        if (resp_q.size() == 0) chk(1'b0, "resp_unexpected", 640'(lce_resp_o), 640'd0);
        else begin
          chk(lce_resp_o == resp_q[0], "resp_fields", 640'(lce_resp_o), 640'(resp_q[0]));
          if (lce_resp_yumi_i) void'(resp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [CMD_W-1:0] c;
    logic [BLK-1:0] d;
    logic [3:0] types [8];
    types[0] = 4'd0; types[1] = 4'd1; types[2] = 4'd2; types[3] = 4'd3;
    types[4] = 4'd4; types[5] = 4'd5; types[6] = 4'd7; types[7] = 4'd15;
    reset_i = 1'b1; lce_id_i = MY_ID; lce_cmd_i = '0; lce_cmd_v_i = 1'b0;
    tag_mem_ready_i = 1'b1; data_mem_ready_i = 1'b1; lce_resp_yumi_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag_mem_v_o, lce_cmd_yumi_o, lce_resp_v_o, init_done_o, error_o, data_mem_v_o} == 6'd0,
        "reset_outputs", 640'({tag_mem_v_o, lce_cmd_yumi_o, lce_resp_v_o, init_done_o, error_o, data_mem_v_o}), 640'd0);
    @(posedge clk); #1 reset_i = 1'b0;

    // Clear sweep: one write per set, then init_done
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      chk(tag_mem_v_o && tag_mem_op_o == 2'd0 && tag_mem_index_o == IDX_W'(i) && tag_mem_way_o == '0 && !init_done_o,
          "clear_write", 640'({tag_mem_v_o, tag_mem_op_o, tag_mem_index_o, init_done_o}),
          640'({1'b1, 2'd0, 6'(i), 1'b0}));
    end
    @(negedge clk);
    chk(init_done_o && !tag_mem_v_o, "init_done", 640'({init_done_o, tag_mem_v_o}), 640'b10);
    @(posedge clk); #1;

    // set_tag stalled on tag array for two cycles
    c = mk(4'd1, 3'd1, 40'h80_0000_1040, 3'd3, '0);
    predict(c);
    tag_mem_ready_i = 1'b0; lce_cmd_i = c; lce_cmd_v_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk(coherence_blocked_o && !lce_cmd_yumi_o, "blocked", 640'({coherence_blocked_o, lce_cmd_yumi_o}), 640'b10);
      @(posedge clk); #1;
    end
    tag_mem_ready_i = 1'b1;
    @(negedge clk);
    chk(lce_cmd_yumi_o && !coherence_blocked_o, "blocked_release", 640'({lce_cmd_yumi_o, coherence_blocked_o}), 640'b10);
    @(posedge clk); #1 lce_cmd_v_i = 1'b0;

    // data fill, uncached dword
    c = mk(4'd3, 3'd0, 40'h12_3456_7980, 3'd5, {64{8'hA5}});
    predict(c); drive_cmd(c, 1'b0);
    d = '0; d[63:0] = 64'hDEADBEEF_CAFEF00D;
    c = mk(4'd4, 3'd0, 40'h0, 3'd0, d);
    predict(c); drive_cmd(c, 1'b0);

    // sync from CCE 2 with response accept delayed three cycles; next command waits
    c = mk(4'd0, 3'd2, 40'h55_0000_0100, 3'd0, '0);
    predict(c); drive_cmd(c, 1'b0);
    d[63:0] = 64'h0123_4567_89AB_CDEF;
    c = mk(4'd4, 3'd0, 40'h0, 3'd0, d);
    predict(c);
    lce_cmd_i = c; lce_cmd_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(lce_resp_v_o && !lce_cmd_yumi_o, "resp_hold", 640'({lce_resp_v_o, lce_cmd_yumi_o}), 640'b10);
      @(posedge clk); #1;
    end
    lce_resp_yumi_i = 1'b1;
    @(posedge clk); #1 lce_resp_yumi_i = 1'b0;
    drive_cmd(c, 1'b0);

    // Unknown command type is consumed and dropped
    c = mk(4'd15, 3'd1, 40'h0, 3'd0, '0);
    predict(c); drive_cmd(c, 1'b0);
    @(negedge clk);
    chk(error_o == ERR_EXP, "error_flag", 640'(error_o), 640'(ERR_EXP));
    @(posedge clk); #1;

    // Randomized commands with random array and response readiness
    resp_auto = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < BLK / 32; k++) d[k*32 +: 32] = $urandom;
      c = mk(types[$urandom_range(0, 7)], 3'($urandom), {8'($urandom), 32'($urandom)}, 3'($urandom), d);
      predict(c); drive_cmd(c, 1'b1);
    end
    for (int i = 0; i < 100 && resp_q.size() != 0; i++) @(posedge clk);
    resp_auto = 1'b0;
    @(posedge clk); #1 lce_resp_yumi_i = 1'b0; tag_mem_ready_i = 1'b1; data_mem_ready_i = 1'b1;
    chk(exp_q.size() == 0 && resp_q.size() == 0, "drain", 640'({exp_q.size(), resp_q.size()}), 640'd0);

    // Reset while a response is pending: response dropped, clear restarts, command stalls
    c = mk(4'd0, 3'd6, 40'h01_0000_0040, 3'd0, '0);
    predict(c); drive_cmd(c, 1'b0);
    @(negedge clk);
    chk(lce_resp_v_o, "resp_pending", 640'(lce_resp_v_o), 640'd1);
    @(posedge clk); #1 reset_i = 1'b1;
    resp_q.delete();
    d[63:0] = 64'hFEED_FACE_0000_0001;
    c = mk(4'd4, 3'd0, 40'h0, 3'd0, d);
    predict(c);
    lce_cmd_i = c; lce_cmd_v_i = 1'b1;
    @(negedge clk);
    chk({lce_resp_v_o, tag_mem_v_o, lce_cmd_yumi_o, init_done_o, error_o} == 5'd0, "reset_mid_resp",
        640'({lce_resp_v_o, tag_mem_v_o, lce_cmd_yumi_o, init_done_o, error_o}), 640'd0);
    @(posedge clk); #1 reset_i = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      chk(!lce_cmd_yumi_o && tag_mem_index_o == IDX_W'(i) && !init_done_o, "stall_in_clear",
          640'({lce_cmd_yumi_o, tag_mem_index_o, init_done_o}), 640'({1'b0, 6'(i), 1'b0}));
    end
    @(posedge clk); #1;
    drive_cmd(c, 1'b0);
    repeat (2) @(posedge clk);
    chk(exp_q.size() == 0 && resp_q.size() == 0, "final_drain", 640'({exp_q.size(), resp_q.size()}), 640'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
